// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: funct3 codes, FSM states,
// and the encoding/alignment classification helpers used at request accept.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the word index carried on mem_addr (byte address bits [31:2]).
    localparam int WIDX_W = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD,
        ST_SW_WR,
        ST_RMW_RD,
        ST_RMW_WR
    } lsu_state_e;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return (lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load lanes, and merges sub-word
// store data into a read word. Halfwords select on addr_lo[1] only.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merge
);

    logic        [7:0]  byte_sel;
    logic        [15:0] half_sel;
    logic signed [31:0] byte_sx;
    logic signed [31:0] half_sx;

    always_comb begin
        byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        byte_sx  = 32'($signed(byte_sel));
        half_sx  = 32'($signed(half_sel));

        case (funct3)
            F3_B:    load_ext = byte_sx;
            F3_BU:   load_ext = {24'b0, byte_sel};
            F3_H:    load_ext = half_sx;
            F3_HU:   load_ext = {16'b0, half_sel};
            default: load_ext = rd_word;
        endcase

        store_merge = rd_word;
        case (funct3)
            F3_B: store_merge[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (addr_lo[1]) begin
                    store_merge[31:16] = wdata[15:0];
                end else begin
                    store_merge[15:0] = wdata[15:0];
                end
            end
            default: store_merge = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-indexed data memory; sub-word stores use read-modify-write.
// Define LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with an error response.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rd_data
);

    lsu_state_e  state_q;
    logic [2:0]  a_funct3_q;
    logic [31:0] a_addr_q;
    logic [31:0] a_wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] merge_q;

    logic [WIDX_W-1:0] req_widx;
    logic              acc_err_d;
    logic              accept;
    logic [31:0]       load_ext;
    logic [31:0]       store_merge;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_widx  = req_addr[31:2];

    always_comb begin
        acc_err_d = f3_illegal(req_we, req_funct3)
                 || ({2'b00, req_widx} >= 32'(MEM_WORDS));
`ifdef LSU_ALIGN_CHECK_EN
        acc_err_d = acc_err_d || f3_misaligned(req_funct3, req_addr[1:0]);
`endif
    end

    lsu_lane_align u_align (
        .funct3      (a_funct3_q),
        .addr_lo     (a_addr_q[1:0]),
        .rd_word     (mem_rd_data),
        .wdata       (a_wdata_q),
        .load_ext    (load_ext),
        .store_merge (store_merge)
    );

    // Request fields are pure data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_funct3_q <= req_funct3;
            a_addr_q   <= req_addr;
            a_wdata_q  <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
            merge_q      <= 32'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (acc_err_d) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!req_we) begin
                            state_q <= ST_LD;
                        end else if (req_funct3 == F3_W) begin
                            state_q <= ST_SW_WR;
                        end else begin
                            state_q <= ST_RMW_RD;
                        end
                    end
                end
                ST_LD: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_ext;
                    state_q      <= ST_IDLE;
                end
                ST_SW_WR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                ST_RMW_RD: begin
                    merge_q <= store_merge;
                    state_q <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are gated by rst so a reset landing in a write state cannot commit the write.
    assign mem_read  = !rst && ((state_q == ST_LD) || (state_q == ST_RMW_RD));
    assign mem_write = !rst && ((state_q == ST_SW_WR) || (state_q == ST_RMW_WR));
    assign mem_addr  = (state_q == ST_IDLE) ? 32'b0 : {2'b00, a_addr_q[31:2]};

    always_comb begin
        case (state_q)
            ST_SW_WR:  mem_wr_data = a_wdata_q;
            ST_RMW_WR: mem_wr_data = merge_q;
            default:   mem_wr_data = 32'b0;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master against a byte-addressed reference memory.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rd_data;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_WORDS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rd_data (mem_rd_data)
    );

    // Word memory seen by the DUT, and a byte-level reference image.
    logic [31:0] mem [64];
    logic [7:0]  refb [256];
    logic        init_we = 1'b0;
    logic [5:0]  init_w  = 6'd0;
    logic [31:0] init_d  = 32'd0;

    assign mem_rd_data = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (init_we) mem[init_w] <= init_d;
        else if (mem_write && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wr_data;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_ea(input logic [2:0] f3, input logic [31:0] a);
        return a - (a % m_size(f3));
    endfunction

    function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit e;
        if (we) e = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    e = f3 inside {3'b011, 3'b110, 3'b111};
        if ((a >> 2) >= 64) e = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        if ((a % m_size(f3)) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    // Expected response; stores update the reference image.
    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output bit e, output logic [31:0] rd);
        int n;
        logic [31:0] ea;
        n  = m_size(f3);
        ea = m_ea(f3, a);
        e  = m_err(we, f3, a);
        rd = 32'h0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < n; i++) refb[ea + i] = 8'(wd >> (8 * i));
        end else begin
            for (int i = 0; i < n; i++) rd = rd | (32'(refb[ea + i]) << (8 * i));
            if (!f3[2] && n < 4 && rd[8 * n - 1]) rd = rd | ~((32'd1 << (8 * n)) - 32'd1);
        end
    endfunction

    task automatic check_word(input int w);
        check($sformatf("word%0d", w), mem[w],
              {refb[4 * w + 3], refb[4 * w + 2], refb[4 * w + 1], refb[4 * w]});
    endtask

    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
        bit e;
        logic [31:0] exp_rd, ea;
        int lat_exp, rd_cnt, wr_cnt, cyc, n;
        n  = m_size(f3);
        ea = m_ea(f3, a);
        model(we, f3, a, wd, e, exp_rd);
        lat_exp = e ? 1 : ((we && n < 4) ? 3 : 2);
        @(negedge clk);
        check("idle_no_resp", {31'b0, resp_valid}, 32'd0);
        check("ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        cyc = 1; rd_cnt = 0; wr_cnt = 0;
        while (1) begin
            if (mem_read)  begin rd_cnt++; check("rd_addr", mem_addr, ea >> 2); end
            if (mem_write) begin wr_cnt++; check("wr_addr", mem_addr, ea >> 2); end
            if (resp_valid) break;
            if (cyc >= 8) begin check("timeout", {31'b0, resp_valid}, 32'd1); break; end
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, lat_exp);
        check("err", {31'b0, resp_err}, {31'b0, e});
        check("rdata", resp_rdata, exp_rd);
        check("reads", rd_cnt, (e || (we && n == 4)) ? 0 : 1);
        check("writes", wr_cnt, (!e && we) ? 1 : 0);
        if (!e && we) check_word(int'(ea >> 2));
        rd = resp_rdata;
    endtask

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        bit          e;
        logic [31:0] rd;
    } exp_t;

    initial begin
        logic [31:0] r;
        logic [31:0] d;
        req_t rq[$];
        exp_t expq[$];
        exp_t x;
        int idx, acc, nresp, guard;
        bit   adv;
        localparam logic [2:0] LD_F3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            d = $urandom;
            init_we = 1'b1; init_w = 6'(w); init_d = d;
            for (int b = 0; b < 4; b++) refb[4 * w + b] = 8'(d >> (8 * b));
        end
        @(negedge clk);
        init_we = 1'b0;

        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wr_data", mem_wr_data, 32'd0);
        rst = 1'b0;

        // Directed scenarios with literal expectations.
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r);
        check("sw_word4", mem[4], 32'hDEADBEEF);
        txn(1'b0, 3'b010, 32'h10, 32'h0, r);  check("lw",  r, 32'hDEADBEEF);
        txn(1'b0, 3'b000, 32'h13, 32'h0, r);  check("lb",  r, 32'hFFFFFFDE);
        txn(1'b0, 3'b100, 32'h13, 32'h0, r);  check("lbu", r, 32'h000000DE);
        txn(1'b0, 3'b001, 32'h12, 32'h0, r);  check("lh",  r, 32'hFFFFDEAD);
        txn(1'b0, 3'b101, 32'h10, 32'h0, r);  check("lhu", r, 32'h0000BEEF);
        txn(1'b1, 3'b000, 32'h11, 32'h55, r);
        check("sb_word4", mem[4], 32'hDEAD55EF);
        txn(1'b1, 3'b001, 32'h12, 32'h1234, r);
        check("sh_word4", mem[4], 32'h123455EF);
        txn(1'b0, 3'b010, 32'h102, 32'h0, r);
        txn(1'b0, 3'b010, 32'h0FE, 32'h0, r);
        txn(1'b0, 3'b011, 32'h20, 32'h0, r);
        txn(1'b1, 3'b100, 32'h20, 32'h1, r);
        txn(1'b1, 3'b101, 32'h24, 32'h2, r);
        txn(1'b0, 3'b010, 32'hFC, 32'h0, r);
        txn(1'b1, 3'b000, 32'h100, 32'h7, r);

        // Reset landing in RMW_WR must suppress the write and the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_rmw_rd", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        check("abort_rmw_wr", {31'b0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_wr_gated", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        check("abort_no_resp2", {31'b0, resp_valid}, 32'd0);
        check_word(8);

        // Randomized single transactions, some illegal or out of range.
        for (int i = 0; i < 150; i++) begin
            txn(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 32'h10F)), $urandom, r);
        end

        // Back-to-back: req_valid held high, alternating loads and stores.
        for (int i = 0; i < 40; i++) begin
            req_t q;
            q.we = (i % 2) == 1;
            q.f3 = q.we ? 3'($urandom_range(0, 2)) : LD_F3[$urandom_range(0, 4)];
            q.a  = 32'($urandom_range(0, 255));
            q.wd = $urandom;
            rq.push_back(q);
        end
        idx = 0; acc = 0; nresp = 0; guard = 0; adv = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = rq[0].we; req_funct3 = rq[0].f3;
        req_addr = rq[0].a; req_wdata = rq[0].wd;
        while (nresp < 40 && guard < 2000) begin
            if (resp_valid) begin
                if (expq.size() == 0) begin
                    check("extra_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    x = expq.pop_front();
                    check("b2b_err", {31'b0, resp_err}, {31'b0, x.e});
                    check("b2b_rdata", resp_rdata, x.rd);
                end
                nresp++;
            end
            if (adv) begin
                idx++;
                if (idx < 40) begin
                    req_we = rq[idx].we; req_funct3 = rq[idx].f3;
                    req_addr = rq[idx].a; req_wdata = rq[idx].wd;
                end else begin
                    req_valid = 1'b0;
                end
            end
            adv = req_valid && req_ready;
            if (adv) begin
                model(rq[idx].we, rq[idx].f3, rq[idx].a, rq[idx].wd, x.e, x.rd);
                expq.push_back(x);
                acc++;
            end
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc, 40);
        check("b2b_responses", nresp, 40);
        repeat (4) begin
            @(negedge clk);
            check("b2b_stray_resp", {31'b0, resp_valid}, 32'd0);
        end

        for (int w = 0; w < 64; w++) check_word(w);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
